// File: rtl/lcd_hex_feeder_if.sv
// Request/status and LCD-controller handshake bundle for lcd_hex_feeder.
// Handshake: load is taken only while the feeder is idle; lcd_home/lcd_write_char are one-cycle strobes issued only after lcd_ready=1, and lcd_char is held until lcd_ready falls and rises again.
interface lcd_hex_feeder_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    busy;
    logic                    done;
    logic                    lcd_ready;
    logic [7:0]              lcd_char;
    logic                    lcd_write_char;
    logic                    lcd_home;

    modport slave (
        input  value, load, lcd_ready,
        output busy, done, lcd_char, lcd_write_char, lcd_home
    );

    modport master (
        output value, load, lcd_ready,
        input  busy, done, lcd_char, lcd_write_char, lcd_home
    );
endinterface

// File: rtl/lcd_hex_feeder.sv
// Converts a captured binary value to ASCII hex and streams it MSB-first to an HD44780 controller.
// Optional "0x" prefix before the digits when LCD_HEX_FEEDER_PREFIX_EN is defined.
module lcd_hex_feeder #(
    parameter int NUM_DIGITS = 8,
    parameter bit UPPERCASE  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    lcd_hex_feeder_if.slave   bus,
    output logic [2:0]        dbg_state_o
);
    localparam int VW    = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOME_WAIT = 3'd1,
        ACK_WAIT  = 3'd2,
        RDY_WAIT  = 3'd3,
        CHAR      = 3'd4
    } state_t;

    state_t           state_q;
    logic [VW-1:0]    shadow_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       char_q;
    logic [7:0]       char_d;
    logic             wr_q;
    logic             home_q;
    logic [3:0]       nib;
`ifdef LCD_HEX_FEEDER_PREFIX_EN
    logic [1:0]       pfx_q;
`endif

    assign nib = shadow_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        char_d = 8'h00;
        if (nib < 4'd10) begin
            char_d = 8'h30 + {4'h0, nib};
        end else begin
            char_d = (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nib};
        end
`ifdef LCD_HEX_FEEDER_PREFIX_EN
        if (pfx_q == 2'd0) begin
            char_d = 8'h30;
        end else if (pfx_q == 2'd1) begin
            char_d = 8'h78;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            char_q   <= 8'h00;
            wr_q     <= 1'b0;
            home_q   <= 1'b0;
`ifdef LCD_HEX_FEEDER_PREFIX_EN
            pfx_q    <= 2'd0;
`endif
        end else begin
            // Strobes and done are single-cycle unless re-asserted below.
            wr_q   <= 1'b0;
            home_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // done_q marks the first idle cycle, where a new load is still refused.
                    if (bus.load && !done_q) begin
                        shadow_q <= bus.value;
                        idx_q    <= IDX_W'(NUM_DIGITS - 1);
                        last_q   <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef LCD_HEX_FEEDER_PREFIX_EN
                        pfx_q    <= 2'd0;
`endif
                        state_q  <= HOME_WAIT;
                    end
                end
                HOME_WAIT: begin
                    if (bus.lcd_ready) begin
                        home_q  <= 1'b1;
                        state_q <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (!bus.lcd_ready) begin
                        state_q <= RDY_WAIT;
                    end
                end
                RDY_WAIT: begin
                    if (bus.lcd_ready) begin
                        if (last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= CHAR;
                        end
                    end
                end
                CHAR: begin
                    char_q  <= char_d;
                    wr_q    <= 1'b1;
                    state_q <= ACK_WAIT;
`ifdef LCD_HEX_FEEDER_PREFIX_EN
                    if (pfx_q != 2'd2) begin
                        pfx_q <= pfx_q + 2'd1;
                    end else if (idx_q == '0) begin
                        last_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
`else
                    if (idx_q == '0) begin
                        last_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.lcd_char       = char_q;
    assign bus.lcd_write_char = wr_q;
    assign bus.lcd_home       = home_q;
    assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_lcd_hex_feeder.sv
// Directed bench: an uppercase and a lowercase feeder share stimulus, each driving its own LCD controller model.
module tb_lcd_hex_feeder;
    localparam int ND = 8;
`ifdef LCD_HEX_FEEDER_PREFIX_EN
    localparam string PFX = "0x";
`else
    localparam string PFX = "";
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic        ready [2] = '{1'b1, 1'b1};
    logic        busy  [2];
    logic        done  [2];
    logic        home  [2];
    logic        wr    [2];
    logic [7:0]  ch    [2];
    logic [2:0]  st_u, st_l;

    lcd_hex_feeder_if #(.NUM_DIGITS(ND)) bus_u ();
    lcd_hex_feeder_if #(.NUM_DIGITS(ND)) bus_l ();

    lcd_hex_feeder #(.NUM_DIGITS(ND), .UPPERCASE(1'b1)) u_up (
        .clk(clk), .reset_n(reset_n), .bus(bus_u), .dbg_state_o(st_u));
    lcd_hex_feeder #(.NUM_DIGITS(ND), .UPPERCASE(1'b0)) u_lo (
        .clk(clk), .reset_n(reset_n), .bus(bus_l), .dbg_state_o(st_l));

    assign bus_u.load = load;        assign bus_l.load = load;
    assign bus_u.value = value;      assign bus_l.value = value;
    assign bus_u.lcd_ready = ready[0]; assign bus_l.lcd_ready = ready[1];
    assign busy[0] = bus_u.busy;     assign busy[1] = bus_l.busy;
    assign done[0] = bus_u.done;     assign done[1] = bus_l.done;
    assign home[0] = bus_u.lcd_home; assign home[1] = bus_l.lcd_home;
    assign wr[0] = bus_u.lcd_write_char; assign wr[1] = bus_l.lcd_write_char;
    assign ch[0] = bus_u.lcd_char;   assign ch[1] = bus_l.lcd_char;

    // Monitor plus LCD controller model, evaluated on the falling edge.
    logic [7:0] got_q0 [$];
    logic [7:0] got_q1 [$];
    int   home_cnt [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   viol_cnt [2] = '{0, 0};
    int   low_cnt  [2] = '{0, 0};
    int   phase    [2] = '{0, 0};
    bit   pend     [2] = '{1'b0, 1'b0};
    logic [7:0] held [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                phase[i] = 0;
            end else begin
                if ((home[i] || wr[i]) && !ready[i]) viol_cnt[i]++;
                if (home[i] && wr[i]) viol_cnt[i]++;
                if (phase[i] != 0 && ch[i] !== held[i]) viol_cnt[i]++;
                if (phase[i] == 1 && !ready[i]) phase[i] = 2;
                else if (phase[i] == 2 && ready[i]) phase[i] = 0;
                if (home[i]) home_cnt[i]++;
                if (done[i]) done_cnt[i]++;
                if (wr[i]) begin
                    held[i] = ch[i];
                    phase[i] = 1;
                    if (i == 0) got_q0.push_back(ch[i]);
                    else got_q1.push_back(ch[i]);
                end
            end
            if (pend[i]) begin
                pend[i] = 1'b0;
                ready[i] = 1'b0;
                low_cnt[i] = 20;
            end else if (low_cnt[i] > 0) begin
                low_cnt[i]--;
                if (low_cnt[i] == 0) ready[i] = 1'b1;
            end
            if (reset_n && (home[i] || wr[i])) pend[i] = 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    task automatic get_str(input int which, input int base, output string s);
        s = "";
        if (which == 0) begin
            for (int k = base; k < got_q0.size(); k++) s = $sformatf("%s%c", s, got_q0[k]);
        end else begin
            for (int k = base; k < got_q1.size(); k++) s = $sformatf("%s%c", s, got_q1[k]);
        end
    endtask

    task automatic wait_done(input string tag);
        int start;
        int n;
        start = done_cnt[0];
        n = 0;
        while (done_cnt[0] == start && n < 5000) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 5000), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_u"}, {busy[0], done[0], wr[0], home[0], ch[0], 5'd0, st_u}, 64'd0);
        check({tag, "_l"}, {busy[1], done[1], wr[1], home[1], ch[1], 5'd0, st_l}, 64'd0);
    endtask

    task automatic run_seq(input string tag, input logic [31:0] v, input string exp_u, input string exp_l);
        int b0, b1, h0, h1, d1;
        string s;
        b0 = got_q0.size(); b1 = got_q1.size();
        h0 = home_cnt[0]; h1 = home_cnt[1]; d1 = done_cnt[1];
        value = v;
        load = 1'b1;
        step();
        load = 1'b0;
        check({tag, "_busy_start"}, 64'(busy[0]), 64'd1);
        wait_done(tag);
        check({tag, "_busy_at_done"}, {busy[0], busy[1], done[0], done[1]}, 64'b0011);
        get_str(0, b0, s);
        check_str({tag, "_chars_u"}, s, exp_u);
        get_str(1, b1, s);
        check_str({tag, "_chars_l"}, s, exp_l);
        check({tag, "_homes"}, 64'((home_cnt[0] - h0) * 16 + (home_cnt[1] - h1)), 64'h11);
        step();
        check({tag, "_done_once"}, 64'(done_cnt[1] - d1), 64'd1);
        check({tag, "_after"}, {busy[0], done[0], busy[1], done[1]}, 64'd0);
        check({tag, "_rules"}, 64'(viol_cnt[0] + viol_cnt[1]), 64'd0);
    endtask

    initial begin
        int b0;
        int n;
        string s;

        // Reset state
        step();
        step();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        step();
        check_idle_outputs("post_reset");

        // Uppercase table from the datasheet example; lowercase twin alongside.
        run_seq("deadbeef", 32'hDEADBEEF, {PFX, "DEADBEEF"}, {PFX, "deadbeef"});

        // First character code checked directly as a byte.
        check("deadbeef_first_byte", 64'(got_q0[got_q0.size() - ND]), 64'h44);
        check("deadbeef_len", 64'(got_q0.size()), 64'(ND + PFX.len()));

        run_seq("abcf", 32'h0000ABCF, {PFX, "0000ABCF"}, {PFX, "0000abcf"});

        // load asserted in the done cycle is refused; the next cycle's load is taken.
        value = 32'h0F0F0F0F;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_done("late_load_seq");
        load = 1'b1;
        step();
        check("load_on_done_ignored", {busy[0], busy[1]}, 64'd0);
        step();
        load = 1'b0;
        check("load_after_done_taken", {busy[0], busy[1]}, 64'b11);
        wait_done("late_load_drain");
        step();

        // load held 5 cycles while value changes: one sequence, first value only.
        b0 = home_cnt[0];
        value = 32'h12345678;
        load = 1'b1;
        step();
        step();
        value = 32'hFFFFFFFF;
        step();
        step();
        step();
        load = 1'b0;
        n = got_q0.size();
        wait_done("hold");
        get_str(0, n - 0, s);
        check_str("hold_chars_u", s, {PFX, "12345678"});
        for (int k = 0; k < 50; k++) step();
        check("hold_single_home", 64'(home_cnt[0] - b0), 64'd1);
        check("hold_idle_after", {busy[0], st_u}, 64'd0);

        // Reset after the third character, then a fresh sequence re-homes.
        b0 = got_q0.size();
        value = 32'h55AA55AA;
        load = 1'b1;
        step();
        load = 1'b0;
        n = 0;
        while (got_q0.size() < b0 + 3 && n < 5000) begin
            step();
            n++;
        end
        check("mid_reset_reach", 64'(n < 5000), 64'd1);
        reset_n = 1'b0;
        step();
        check_idle_outputs("mid_reset");
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step();
        run_seq("after_reset", 32'h00000001, {PFX, "00000001"}, {PFX, "00000001"});

        run_seq("cafef00d", 32'hCAFEF00D, {PFX, "CAFEF00D"}, {PFX, "cafef00d"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
